// File: rtl/dual_adc_capture.sv
// Dual-channel ADC capture: armed slope/forced trigger, DEPTH-pair buffer,
// ready/valid readout of {OTR2, ch2, OTR1, ch1} in capture order.
module dual_adc_capture #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 256
) (
  input  logic                  clk_20M,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     ad_data1,
  input  logic [DATA_W-1:0]     ad_data2,
  input  logic                  OTR1,
  input  logic                  OTR2,
  input  logic                  arm,
  input  logic                  force_trig,
  input  logic [DATA_W-1:0]     trig_level,
  input  logic                  trig_edge,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [2*DATA_W+1:0]   out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            otr_sticky
);

  localparam int PAIR_W = 2*DATA_W + 2;
  localparam int AW     = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};
  localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    CAPTURE   = 2'd2,
    READOUT   = 2'd3
  } state_t;

  // input stage
  logic [DATA_W-1:0] s1_q, s1_d, s2_q, s2_d, s1_dly_q, s1_dly_d;
  logic              o1_q, o1_d, o2_q, o2_d;

  // control
  state_t            state_q, state_d;
  logic              first_q, first_d;
  logic [AW-1:0]     wr_addr_q, wr_addr_d;
  logic [1:0]        sticky_q, sticky_d;
  logic              wr_en;
  logic [PAIR_W-1:0] wr_data;
  logic              rise_hit, fall_hit, slope_hit;

  // readout pipeline
  logic [AW-1:0]     rd_addr_q, rd_addr_d;
  logic              rd_done_q, rd_done_d;
  logic              ram_vld_q, ram_vld_d;
  logic              ram_last_q, ram_last_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [PAIR_W-1:0] out_data_q, out_data_d;
  logic              rd_en;
  logic              out_load;
  logic              accept;

  logic [PAIR_W-1:0] mem [DEPTH];
  logic [PAIR_W-1:0] ram_q;

  assign wr_data   = {o2_q, s2_q, o1_q, s1_q};
  assign rise_hit  = (s1_dly_q < trig_level) && (s1_q >= trig_level);
  assign fall_hit  = (s1_dly_q >= trig_level) && (s1_q < trig_level);
  assign slope_hit = trig_edge ? fall_hit : rise_hit;
  assign accept    = out_valid_q & out_ready;

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign otr_sticky = sticky_q;
  assign busy       = (state_q != IDLE);
  // done must coincide with acceptance of the last beat, while still in READOUT
  assign done       = accept & out_last_q;

  // Input register next values: one stage for both channels, one extra for ch1.
  always_comb begin
    s1_d     = ad_data1;
    s2_d     = ad_data2;
    o1_d     = OTR1;
    o2_d     = OTR2;
    s1_dly_d = s1_q;
  end

  // Next-state, write-side addressing and out-of-range latching.
  always_comb begin
    state_d   = state_q;
    first_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    sticky_d  = sticky_q;
    wr_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (arm) begin
          state_d   = WAIT_TRIG;
          first_d   = 1'b1;
          wr_addr_d = {AW{1'b0}};
          sticky_d  = 2'b00;
        end else begin
          state_d   = IDLE;
        end
      end
      WAIT_TRIG: begin
        // s1_dly is not yet meaningful on the first waiting cycle
        if (!first_q && (force_trig || slope_hit)) begin
          state_d   = CAPTURE;
          wr_en     = 1'b1;
          wr_addr_d = wr_addr_q + ADDR_ONE;
          sticky_d  = sticky_q | {o2_q, o1_q};
        end else begin
          state_d   = WAIT_TRIG;
        end
      end
      CAPTURE: begin
        wr_en     = 1'b1;
        wr_addr_d = wr_addr_q + ADDR_ONE;
        sticky_d  = sticky_q | {o2_q, o1_q};
        if (wr_addr_q == LAST_ADDR) begin
          state_d = READOUT;
        end else begin
          state_d = CAPTURE;
        end
      end
      READOUT: begin
        if (accept && out_last_q) begin
          state_d = IDLE;
        end else begin
          state_d = READOUT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Two-stage read pipeline (RAM output, output register) that only advances
  // into free slots, so stalls never drop or repeat a beat.
  always_comb begin
    rd_addr_d   = rd_addr_q;
    rd_done_d   = rd_done_q;
    ram_vld_d   = ram_vld_q;
    ram_last_d  = ram_last_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    rd_en       = 1'b0;
    out_load    = 1'b0;
    if (state_q == READOUT) begin
      out_load = !out_valid_q || accept;
      if (out_load) begin
        out_valid_d = ram_vld_q;
        out_last_d  = ram_last_q;
        out_data_d  = ram_q;
      end else begin
        out_valid_d = out_valid_q;
      end
      rd_en = !rd_done_q && (!ram_vld_q || out_load);
      if (rd_en) begin
        rd_addr_d  = rd_addr_q + ADDR_ONE;
        rd_done_d  = (rd_addr_q == LAST_ADDR);
        ram_vld_d  = 1'b1;
        ram_last_d = (rd_addr_q == LAST_ADDR);
      end else if (out_load) begin
        ram_vld_d  = 1'b0;
        ram_last_d = 1'b0;
      end else begin
        ram_vld_d  = ram_vld_q;
      end
    end else begin
      rd_addr_d   = {AW{1'b0}};
      rd_done_d   = 1'b0;
      ram_vld_d   = 1'b0;
      ram_last_d  = 1'b0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_20M) begin
    if (rst) begin
      s1_q        <= {DATA_W{1'b0}};
      s2_q        <= {DATA_W{1'b0}};
      s1_dly_q    <= {DATA_W{1'b0}};
      o1_q        <= 1'b0;
      o2_q        <= 1'b0;
      state_q     <= IDLE;
      first_q     <= 1'b0;
      wr_addr_q   <= {AW{1'b0}};
      sticky_q    <= 2'b00;
      rd_addr_q   <= {AW{1'b0}};
      rd_done_q   <= 1'b0;
      ram_vld_q   <= 1'b0;
      ram_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= {PAIR_W{1'b0}};
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s1_dly_q    <= s1_dly_d;
      o1_q        <= o1_d;
      o2_q        <= o2_d;
      state_q     <= state_d;
      first_q     <= first_d;
      wr_addr_q   <= wr_addr_d;
      sticky_q    <= sticky_d;
      rd_addr_q   <= rd_addr_d;
      rd_done_q   <= rd_done_d;
      ram_vld_q   <= ram_vld_d;
      ram_last_q  <= ram_last_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  // Simple dual-port sample buffer; contents survive reset, read holds when idle.
  always_ff @(posedge clk_20M) begin
    if (wr_en) begin
      mem[wr_addr_q] <= wr_data;
    end
    if (rd_en) begin
      ram_q <= mem[rd_addr_q];
    end
  end

endmodule

// File: tb/tb_dual_adc_capture.sv
// Directed bench for dual_adc_capture: ramp, falling slope, backpressure,
// OTR latching, reset abort and arm rejection with hand-derived expectations.
`timescale 1ns/1ps
module tb_dual_adc_capture;

  localparam int DW    = 10;
  localparam int DEPTH = 256;
  localparam int PW    = 2*DW + 2;

  logic          clk_20M = 1'b0;
  logic          rst;
  logic [DW-1:0] ad_data1, ad_data2;
  logic          OTR1, OTR2;
  logic          arm, force_trig;
  logic [DW-1:0] trig_level;
  logic          trig_edge;
  logic          out_ready;
  logic          out_valid;
  logic [PW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;
  logic [1:0]    otr_sticky;

  int            n_vec = 0;
  int            n_err = 0;
  logic          ramp_en = 1'b0;
  logic [15:0]   lfsr = 16'hACE1;
  logic [PW-1:0] beats [DEPTH];
  logic          lasts [DEPTH];
  int            nacc, ndone, done_idx;
  int            cnt, bad;

  dual_adc_capture #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk_20M    (clk_20M),
    .rst        (rst),
    .ad_data1   (ad_data1),
    .ad_data2   (ad_data2),
    .OTR1       (OTR1),
    .OTR2       (OTR2),
    .arm        (arm),
    .force_trig (force_trig),
    .trig_level (trig_level),
    .trig_edge  (trig_edge),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .otr_sticky (otr_sticky)
  );

  always #5 clk_20M = ~clk_20M;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input logic [DW-1:0] v);
    ad_data1 = v;
    ad_data2 = ~v;
  endtask

  task automatic tick();
    @(posedge clk_20M);
    #1;
    if (ramp_en) set_ch(ad_data1 + 10'd1);
  endtask

  // Ramp restarts at 0; forced trigger makes beat i carry ch1 = i.
  task automatic force_ramp_capture();
    set_ch(10'd0);
    ramp_en = 1'b1;
    tick();
    force_trig = 1'b1;
    tick();
    force_trig = 1'b0;
  endtask

  task automatic run_readout(input bit bp);
    logic [PW-1:0] held;
    logic          held_last;
    bit            stalled;
    bit            r;
    int            cyc;
    stalled = 1'b0; held = '0; held_last = 1'b0; cyc = 0;
    nacc = 0; ndone = 0; done_idx = -1;
    while (nacc < DEPTH && cyc < 4000) begin
      if (bp) begin
        lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        r = lfsr[0];
      end else begin
        r = 1'b1;
      end
      out_ready = r;
      #1;
      if (stalled) begin
        check_val("hold_valid", out_valid, 32'd1);
        check_val("hold_data", out_data, held);
        check_val("hold_last", out_last, held_last);
      end
      if (done) begin
        ndone++;
        done_idx = nacc;
      end
      if (out_valid && r) begin
        beats[nacc] = out_data;
        lasts[nacc] = out_last;
        nacc++;
      end
      stalled   = out_valid && !r;
      held      = out_data;
      held_last = out_last;
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    check_val("beats_accepted", nacc, DEPTH);
    check_val("done_pulses", ndone, 32'd1);
    check_val("done_on_last", done_idx, DEPTH - 1);
    check_val("valid_after_done", out_valid, 32'd0);
    check_val("busy_after_done", busy, 32'd0);
    check_val("done_after", done, 32'd0);
  endtask

  task automatic check_beats(input logic [DW-1:0] base, input bit step, input int otr_idx);
    for (int i = 0; i < DEPTH; i++) begin
      logic [DW-1:0] c;
      logic [PW-1:0] e;
      c = step ? base + DW'(i) : base;
      e = {(i == otr_idx), ~c, 1'b0, c};
      check_val($sformatf("beat%0d", i), beats[i], e);
      check_val($sformatf("last%0d", i), lasts[i], (i == DEPTH - 1));
    end
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; force_trig = 1'b0; trig_level = 10'd0; trig_edge = 1'b0;
    out_ready = 1'b0; OTR1 = 1'b0; OTR2 = 1'b0;
    set_ch(10'd0);
    tick();
    tick();
    check_val("rst_busy", busy, 32'd0);
    check_val("rst_valid", out_valid, 32'd0);
    check_val("rst_last", out_last, 32'd0);
    check_val("rst_done", done, 32'd0);
    check_val("rst_sticky", otr_sticky, 32'd0);
    rst = 1'b0;
    tick();

    // rising ramp trigger at 512
    trig_level = 10'd512; trig_edge = 1'b0;
    arm = 1'b1; tick(); arm = 1'b0;
    check_val("arm_busy", busy, 32'd1);
    ramp_en = 1'b1;
    run_readout(1'b0);
    check_beats(10'd512, 1'b1, -1);
    ramp_en = 1'b0;

    // falling slope 700 -> 300, OTR2 pulsed only while waiting
    trig_level = 10'd500; trig_edge = 1'b1;
    set_ch(10'd700);
    tick(); tick();
    arm = 1'b1; tick(); arm = 1'b0;
    tick();
    OTR2 = 1'b1; tick(); OTR2 = 1'b0;
    tick(); tick();
    check_val("fall_wait_busy", busy, 32'd1);
    check_val("fall_wait_valid", out_valid, 32'd0);
    set_ch(10'd300);
    cnt = 0;
    while (!out_valid && cnt < 1000) begin tick(); cnt++; end
    check_val("fall_valid_rise", out_valid, 32'd1);
    arm = 1'b1; tick(); arm = 1'b0;
    check_val("arm_rd_valid", out_valid, 32'd1);
    check_val("arm_rd_busy", busy, 32'd1);
    check_val("arm_rd_data", out_data, {1'b0, ~10'd300, 1'b0, 10'd300});
    run_readout(1'b0);
    check_beats(10'd300, 1'b0, -1);
    check_val("otr_wait_only", otr_sticky, 32'd0);

    // force_trig without arm after done
    force_trig = 1'b1;
    repeat (6) tick();
    force_trig = 1'b0;
    check_val("noarm_busy", busy, 32'd0);
    check_val("noarm_valid", out_valid, 32'd0);

    // steady 300 with rising slope never triggers
    trig_edge = 1'b0;
    arm = 1'b1; tick(); arm = 1'b0;
    repeat (40) tick();
    check_val("steady_busy", busy, 32'd1);
    check_val("steady_valid", out_valid, 32'd0);

    // forced capture of a fresh ramp with OTR2 on pair 50, random backpressure
    force_ramp_capture();
    cnt = 0;
    while (ad_data1 != 10'd50 && cnt < 100) begin tick(); cnt++; end
    OTR2 = 1'b1; tick(); OTR2 = 1'b0;
    run_readout(1'b1);
    check_beats(10'd0, 1'b1, 50);
    check_val("otr2_sticky", otr_sticky, 32'd2);

    // new arm clears sticky; reset at pair ~100 aborts the capture
    arm = 1'b1; tick(); arm = 1'b0;
    check_val("sticky_clr_arm", otr_sticky, 32'd0);
    force_ramp_capture();
    repeat (99) tick();
    check_val("abort_pre_busy", busy, 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    check_val("abort_busy", busy, 32'd0);
    check_val("abort_valid", out_valid, 32'd0);
    check_val("abort_done", done, 32'd0);
    check_val("abort_sticky", otr_sticky, 32'd0);
    out_ready = 1'b1;
    bad = 0;
    repeat (300) begin
      tick();
      if (out_valid || done || busy) bad++;
    end
    out_ready = 1'b0;
    check_val("abort_quiet", bad, 32'd0);

    // fresh arm + force after abort completes normally
    arm = 1'b1; tick(); arm = 1'b0;
    force_ramp_capture();
    run_readout(1'b0);
    check_beats(10'd0, 1'b1, -1);
    ramp_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
